// File: rtl/net_bus_pkg.sv
// ----------------------------------------------------------------------------
// net_bus_pkg
// Shared definitions for the NetBus slices: flit header bit positions, ID
// width, flit width helper and the transmit-slice FSM state encoding.
// ----------------------------------------------------------------------------
package net_bus_pkg;

    localparam int LAST   = 0;   // header bit: last flit of a frame
    localparam int FIRST  = 1;   // header bit: first flit of a frame
    localparam int SRC_LO = 2;   // header [6:2]  source ID
    localparam int DST_LO = 7;   // header [11:7] destination ID
    localparam int HDR_W  = 14;  // header width, [13:12] reserved zero
    localparam int ID_W   = 5;
    localparam int LANE_W = 9;   // bits per payload lane

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DROP  = 2'd2,
        TRUNC = 2'd3
    } state_t;

    // Full flit width for a given number of payload lanes.
    function automatic int flit_width(input int data_width);
        return data_width * LANE_W + HDR_W;
    endfunction

endpackage

// File: rtl/net_bus_slice_tx_if.sv
// ----------------------------------------------------------------------------
// net_bus_slice_tx_if
// Groups the source-side beat handshake (S*) and the bus-side flit handshake
// (T*) of the transmit slice.
//   slave  : view of the transmit slice (consumes S*, produces T*)
//   master : view of the environment   (produces S*, consumes T*)
// ----------------------------------------------------------------------------
interface net_bus_slice_tx_if #(
    parameter int DATA_WIDTH = 4
);
    import net_bus_pkg::*;

    logic [DATA_WIDTH*LANE_W-1:0]        SDATA;
    logic [ID_W-1:0]                     SDEST;
    logic                                SLAST;
    logic                                SVALID;
    logic                                SREADY;
    logic [flit_width(DATA_WIDTH)-1:0]   TDATA;
    logic                                TVALID;
    logic                                TREADY;

    modport slave (
        input  SDATA, SDEST, SLAST, SVALID,
        output SREADY,
        output TDATA, TVALID,
        input  TREADY
    );

    modport master (
        output SDATA, SDEST, SLAST, SVALID,
        input  SREADY,
        input  TDATA, TVALID,
        output TREADY
    );

endinterface

// File: rtl/net_bus_skid_buf.sv
// ----------------------------------------------------------------------------
// net_bus_skid_buf
// Two-entry register slice with valid/ready on both sides. The input ready is
// a register (no combinational path from i_out_ready to o_in_ready); it is
// high whenever at least one entry will be free in the coming cycle.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_in_data/valid, o_in_ready    upstream handshake
//   o_out_data/valid, i_out_ready  downstream handshake
// ----------------------------------------------------------------------------
module net_bus_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push       = i_in_valid & r_ready;
    assign w_pop        = (r_count != 2'd0) & i_out_ready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            // Look ahead at next occupancy so ready is a pure register.
            r_ready <= (w_count_next != 2'd2);
        end
    end

    assign o_in_ready  = r_ready;
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/net_bus_slice_tx.sv
// ----------------------------------------------------------------------------
// net_bus_slice_tx
// Injection end of the NetBus: stamps each source beat with a 14-bit flit
// header, drops frames to unroutable destinations, truncates frames longer
// than MAX_BEATS and forwards flits through a 2-entry skid buffer.
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   bus           S*/T* handshakes (net_bus_slice_tx_if.slave)
//   TFRAME        output frame open (first flit sent, last not yet)
//   ERR_PULSE     one-cycle pulse per dropped or truncated frame
//   ERR_CNT       saturating count of dropped plus truncated frames
// ----------------------------------------------------------------------------
module net_bus_slice_tx
    import net_bus_pkg::*;
#(
    parameter int           DATA_WIDTH = 4,
    parameter logic [4:0]   SRC_ID     = 5'd0,
    parameter logic [31:0]  ROUTE_MASK = 32'hFFFF_FFFF,
    parameter int           MAX_BEATS  = 256
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    net_bus_slice_tx_if.slave     bus,
    output logic                  TFRAME,
    output logic                  ERR_PULSE,
    output logic [15:0]           ERR_CNT
);

    localparam int              FW      = flit_width(DATA_WIDTH);
    localparam int              CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ID_W-1:0]   r_dest;
    logic [ID_W-1:0]   w_dest_next;
    logic [ID_W-1:0]   w_hdr_dest;
    logic              r_tframe;
    logic              r_err_pulse;
    logic [15:0]       r_err_cnt;

    logic              w_skid_ready;
    logic              w_sready;
    logic              w_accept;
    logic              w_routable;
    logic              w_push;
    logic              w_first;
    logic              w_last;
    logic              w_err;
    logic [HDR_W-1:0]  w_hdr;
    logic [FW-1:0]     w_flit;

    // DROP/TRUNC discard beats, so they never need buffer space.
    assign w_sready   = w_skid_ready | (r_state == DROP) | (r_state == TRUNC);
    assign bus.SREADY = w_sready;
    assign w_accept   = bus.SVALID & w_sready;
    assign w_routable = ROUTE_MASK[bus.SDEST];
    assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_dest     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_dest     <= w_dest_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        w_dest_next     = r_dest;
        w_hdr_dest      = r_dest;
        w_push          = 1'b0;
        w_first         = 1'b0;
        w_last          = 1'b0;
        w_err           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_routable) begin
                        w_push          = 1'b1;
                        w_first         = 1'b1;
                        w_hdr_dest      = bus.SDEST;
                        w_dest_next     = bus.SDEST;
                        w_beat_cnt_next = CNT_W'(1);
                        if (bus.SLAST) begin
                            w_last = 1'b1;
                        end else begin
                            w_state_next = PASS;
                        end
                    end else begin
                        w_err = 1'b1;
                        if (!bus.SLAST) begin
                            w_state_next = DROP;
                        end
                    end
                end
            end
            PASS: begin
                if (w_accept) begin
                    w_push          = 1'b1;
                    w_beat_cnt_next = w_cnt_inc;
                    if (bus.SLAST) begin
                        w_last       = 1'b1;
                        w_state_next = IDLE;
                    end else if (w_cnt_inc == MAX_CNT) begin
                        // Close the frame early; the tail is swallowed in TRUNC.
                        w_last       = 1'b1;
                        w_err        = 1'b1;
                        w_state_next = TRUNC;
                    end
                end
            end
            default: begin
                if (w_accept && bus.SLAST) begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_hdr                        = '0;
        w_hdr[LAST]                  = w_last;
        w_hdr[FIRST]                 = w_first;
        w_hdr[SRC_LO +: ID_W]        = SRC_ID;
        w_hdr[DST_LO +: ID_W]        = w_hdr_dest;
    end

    assign w_flit = {bus.SDATA, w_hdr};

    net_bus_skid_buf #(
        .WIDTH (FW)
    ) u_skid (
        .i_clk       (CLK),
        .i_rst_n     (RESETn),
        .i_in_data   (w_flit),
        .i_in_valid  (w_push),
        .o_in_ready  (w_skid_ready),
        .o_out_data  (bus.TDATA),
        .o_out_valid (bus.TVALID),
        .i_out_ready (bus.TREADY)
    );

    // TFRAME follows the flits actually handed to the bus, not the input side.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_tframe    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 16'd0;
        end else begin
            if (bus.TVALID && bus.TREADY) begin
                if (bus.TDATA[LAST]) begin
                    r_tframe <= 1'b0;
                end else if (bus.TDATA[FIRST]) begin
                    r_tframe <= 1'b1;
                end
            end
            r_err_pulse <= w_err;
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign TFRAME    = r_tframe;
    assign ERR_PULSE = r_err_pulse;
    assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_net_bus_slice_tx.sv
// ----------------------------------------------------------------------------
// tb_net_bus_slice_tx
// Scoreboard bench for net_bus_slice_tx: expected flits are queued when a
// source beat is accepted and compared when the slice hands a flit to the bus.
// DUT configuration: SRC_ID=3, destinations 0 and 5 routable, MAX_BEATS=4.
// ----------------------------------------------------------------------------
module tb_net_bus_slice_tx;
    import net_bus_pkg::*;

    localparam int          DW   = 4;
    localparam int          FW   = DW * 9 + 14;
    localparam logic [4:0]  SRC  = 5'd3;
    localparam logic [31:0] MASK = 32'h0000_0021;
    localparam int          MAXB = 4;

    logic        CLK    = 1'b0;
    logic        RESETn = 1'b0;
    logic        TFRAME;
    logic        ERR_PULSE;
    logic [15:0] ERR_CNT;

    net_bus_slice_tx_if #(.DATA_WIDTH(DW)) bus_if ();

    net_bus_slice_tx #(
        .DATA_WIDTH (DW),
        .SRC_ID     (SRC),
        .ROUTE_MASK (MASK),
        .MAX_BEATS  (MAXB)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .bus       (bus_if),
        .TFRAME    (TFRAME),
        .ERR_PULSE (ERR_PULSE),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [FW-1:0] exp_q[$];
    int            m_state  = 0;   // 0 idle, 1 passing, 2 discarding
    int            m_cnt    = 0;
    logic [4:0]    m_dest   = '0;
    int            m_err    = 0;
    int            obs_pulses = 0;
    int            occ      = 0;
    int            cyc      = 0;
    bit            rand_mode   = 0;
    bit            chk_ready   = 0;
    bit            chk_noframe = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input logic [35:0] d, input logic [4:0] dst,
                                              input bit first, input bit last);
        return {d, 2'b00, dst, SRC, first, last};
    endfunction

    task automatic model_accept(input logic [35:0] d, input logic [4:0] dst, input bit last);
        logic [31:0] mask_v;
        mask_v = MASK;
        case (m_state)
            0: begin
                if (mask_v[dst]) begin
                    exp_q.push_back(mk_flit(d, dst, 1'b1, last));
                    if (!last) begin
                        m_state = 1;
                        m_cnt   = 1;
                        m_dest  = dst;
                    end
                end else begin
                    m_err++;
                    if (!last) m_state = 2;
                end
            end
            1: begin
                m_cnt++;
                if (last) begin
                    exp_q.push_back(mk_flit(d, m_dest, 1'b0, 1'b1));
                    m_state = 0;
                end else if (m_cnt == MAXB) begin
                    exp_q.push_back(mk_flit(d, m_dest, 1'b0, 1'b1));
                    m_err++;
                    m_state = 2;
                end else begin
                    exp_q.push_back(mk_flit(d, m_dest, 1'b0, 1'b0));
                end
            end
            default: begin
                if (last) m_state = 0;
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_beat(input logic [35:0] d, input logic [4:0] dst, input bit last);
        int n;
        bus_if.SDATA  = d;
        bus_if.SDEST  = dst;
        bus_if.SLAST  = last;
        bus_if.SVALID = 1'b1;
        n = 0;
        while (!bus_if.SREADY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            check_val("sready_timeout", 64'(n), 64'd0);
            bus_if.SVALID = 1'b0;
            return;
        end
        model_accept(d, dst, last);
        @(negedge CLK);
        bus_if.SVALID = 1'b0;
    endtask

    // Mid-frame beats carry random destinations, which the slice must ignore.
    task automatic send_frame(input logic [4:0] dst, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            send_beat({4'(i), 32'($urandom)}, (i == 0) ? dst : 5'($urandom), i == nbeats - 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.TVALID) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check_val("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Bus-side ready: always 1, or high 30% of cycles in random mode.
    initial begin
        bus_if.TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            bus_if.TREADY = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Skid occupancy seen from outside, counted only while every accept is a flit.
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RESETn || !chk_ready) begin
                occ = 0;
            end else begin
                occ = occ + ((bus_if.SVALID && bus_if.SREADY) ? 1 : 0)
                          - ((bus_if.TVALID && bus_if.TREADY) ? 1 : 0);
            end
        end
    end

    // Output monitor and scoreboard compare.
    initial begin
        logic [FW-1:0] prev_data;
        logic [FW-1:0] e;
        bit            prev_stall;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                prev_stall = 0;
                continue;
            end
            if (ERR_PULSE) obs_pulses++;
            if (prev_stall) check_val("tdata_stable", 64'(bus_if.TDATA), 64'(prev_data));
            if (chk_ready) check_val("sready_vs_occupancy", 64'(bus_if.SREADY), 64'(occ < 2));
            if (chk_noframe) check_val("tframe_low_single", 64'(TFRAME), 64'd0);
            if (bus_if.TVALID && bus_if.TREADY) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_flit", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    $display("flit data=%09h dst=%0d src=%0d first=%0b last=%0b",
                             bus_if.TDATA[FW-1:14], bus_if.TDATA[11:7], bus_if.TDATA[6:2],
                             bus_if.TDATA[1], bus_if.TDATA[0]);
                    check_val("flit", 64'(bus_if.TDATA), 64'(e));
                end
            end
            prev_stall = bus_if.TVALID && !bus_if.TREADY;
            prev_data  = bus_if.TDATA;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bus_if.SVALID = 1'b0;
        bus_if.SDATA  = '0;
        bus_if.SDEST  = '0;
        bus_if.SLAST  = 1'b0;
        RESETn        = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check_val("rst_tvalid", 64'(bus_if.TVALID), 64'd0);
        check_val("rst_tdata",  64'(bus_if.TDATA),  64'd0);
        check_val("rst_tframe", 64'(TFRAME),        64'd0);
        check_val("rst_errp",   64'(ERR_PULSE),     64'd0);
        check_val("rst_errcnt", 64'(ERR_CNT),       64'd0);
        check_val("rst_sready", 64'(bus_if.SREADY), 64'd0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("sready_after_reset", 64'(bus_if.SREADY), 64'd1);

        // 3-beat frame to dest 5: latency and TFRAME window
        check_val("tvalid_idle", 64'(bus_if.TVALID), 64'd0);
        send_beat(36'h1_0000_0001, 5'd5, 1'b0);
        check_val("latency_tvalid", 64'(bus_if.TVALID), 64'd1);
        check_val("first_hdr", 64'(bus_if.TDATA[13:0]), 64'h02 | (64'd3 << 2) | (64'd5 << 7));
        check_val("tframe_before_xfer", 64'(TFRAME), 64'd0);
        send_beat(36'h2_0000_0002, 5'd9, 1'b0);
        check_val("tframe_open", 64'(TFRAME), 64'd1);
        send_beat(36'h3_0000_0003, 5'd1, 1'b1);
        check_val("tframe_still_open", 64'(TFRAME), 64'd1);
        @(negedge CLK);
        check_val("tframe_closed", 64'(TFRAME), 64'd0);
        drain();

        // Unroutable destination: whole frame swallowed
        send_frame(5'd2, 4);
        repeat (2) @(negedge CLK);
        check_val("drop_no_tvalid", 64'(bus_if.TVALID), 64'd0);
        check_val("err_cnt_drop",   64'(ERR_CNT),       64'd1);
        check_val("err_pulses_drop", 64'(obs_pulses),   64'd1);
        send_frame(5'd0, 3);
        drain();

        // Over-length frame truncated after MAX_BEATS flits
        send_frame(5'd5, 6);
        drain();
        repeat (2) @(negedge CLK);
        check_val("err_cnt_trunc", 64'(ERR_CNT), 64'd2);
        check_val("err_pulses_trunc", 64'(obs_pulses), 64'd2);

        // 20-beat stream under random back-pressure
        chk_ready = 1;
        rand_mode = 1;
        for (int f = 0; f < 5; f++) begin
            send_frame((f % 2) ? 5'd5 : 5'd0, 4);
        end
        rand_mode = 0;
        drain();
        chk_ready = 0;

        // Back-to-back single-beat frames at full rate
        repeat (2) @(negedge CLK);
        chk_noframe = 1;
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            send_beat({4'hA, 32'($urandom)}, 5'd5, 1'b1);
        end
        check_val("b2b_cycles", 64'(cyc - t0), 64'd6);
        drain();
        @(negedge CLK);
        chk_noframe = 0;

        // Asynchronous reset on beat 2 of a 5-beat frame
        send_beat(36'h1_1111_1111, 5'd5, 1'b0);
        send_beat(36'h2_2222_2222, 5'd5, 1'b0);
        check_val("pre_reset_tframe", 64'(TFRAME), 64'd1);
        check_val("pre_reset_tvalid", 64'(bus_if.TVALID), 64'd1);
        #2;
        RESETn = 1'b0;
        #1;
        check_val("async_rst_tvalid", 64'(bus_if.TVALID), 64'd0);
        check_val("async_rst_tframe", 64'(TFRAME),        64'd0);
        check_val("async_rst_sready", 64'(bus_if.SREADY), 64'd0);
        exp_q.delete();
        m_state    = 0;
        m_err      = 0;
        obs_pulses = 0;
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("err_cnt_after_reset", 64'(ERR_CNT), 64'd0);
        send_frame(5'd5, 2);
        drain();

        repeat (2) @(negedge CLK);
        check_val("final_err_cnt", 64'(ERR_CNT), 64'(m_err));
        check_val("final_err_pulses", 64'(obs_pulses), 64'(m_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
